// File: rtl/dvp_stream_pkg.sv
// Shared types and helpers for the multi-channel line aligner.
// Flag bits sit directly above the pixel field in each buffered word.
package dvp_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SEND  = 2'd2,
        DROP  = 2'd3
    } state_t;

    function automatic int sof_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int eol_bit(input int data_w);
        return data_w + 1;
    endfunction

    // Bits needed to index n entries; never less than 1.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on o_rd_data
// whenever o_used is non-zero. Writes while full and reads while empty are ignored.
module line_fifo
    import dvp_stream_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2048
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_full,
    output logic [clog2w(DEPTH):0]  o_used
);
    localparam int AW = clog2w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_used  = r_wr_ptr - r_rd_ptr;
    assign w_wr    = i_wr_en & ~o_full;
    assign w_rd    = i_rd_en & ~w_empty;

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/stereo_line_aligner.sv
// Buffers NUM_CH camera streams per line and emits them as one aligned pixel
// vector, resynchronising channels on start-of-frame and trimming length mismatches.
//
// state | meaning
// IDLE  | wait until every channel holds at least one complete line
// ALIGN | compare head sof flags: all/none -> SEND, mixed -> DROP
// SEND  | pop all channels together on each accepted output pixel
// DROP  | pop only the masked channels until each has popped its eol
module stereo_line_aligner
    import dvp_stream_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DATA_W          = 8,
    parameter int FIFO_DEPTH      = 2048,
    parameter int LINES_PER_FRAME = 720,
    parameter int MAX_SKEW        = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_sof,
    input  logic [NUM_CH-1:0]        in_eol,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    input  logic                     clr_err,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        len_err,
    output logic [NUM_CH-1:0]        skew_err,
    output logic [7:0]               frame_cnt,
    output logic [7:0]               drop_cnt
);
    localparam int WORD_W = DATA_W + 2;
    localparam int SOF_B  = sof_bit(DATA_W);
    localparam int EOL_B  = eol_bit(DATA_W);
    localparam int UW     = clog2w(FIFO_DEPTH) + 1;
    localparam int OLW    = clog2w(LINES_PER_FRAME);
    localparam logic [OLW-1:0] LAST_LINE = OLW'(LINES_PER_FRAME - 1);

    logic [NUM_CH-1:0]        w_wr;
    logic [NUM_CH-1:0]        w_full;
    logic [NUM_CH-1:0]        w_empty;
    logic [NUM_CH-1:0]        w_pop;
    logic [NUM_CH-1:0]        w_head_sof;
    logic [NUM_CH-1:0]        w_head_eol;
    logic [NUM_CH-1:0]        w_wr_eol;
    logic [NUM_CH-1:0]        w_pop_eol;
    logic [NUM_CH-1:0]        w_has_line;
    logic [NUM_CH-1:0]        w_skew_now;
    logic [NUM_CH-1:0]        w_len_evt;
    logic [NUM_CH-1:0]        w_drop_left;
    logic [UW-1:0]            w_used [NUM_CH];
    logic [WORD_W-1:0]        w_head [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] w_head_data;
    logic [UW-1:0]            w_min_lcnt;
    logic [OLW-1:0]           w_line_now;
    logic                     w_accept;

    state_t                   r_state;
    logic                     r_out_valid;
    logic [UW-1:0]            r_lcnt [NUM_CH];
    logic [NUM_CH-1:0]        r_armed;
    logic [NUM_CH-1:0]        r_skew_prev;
    logic [NUM_CH-1:0]        r_drop_mask;
    logic [NUM_CH-1:0]        r_overflow;
    logic [NUM_CH-1:0]        r_len_err;
    logic [NUM_CH-1:0]        r_skew_err;
    logic [7:0]               r_frame_cnt;
    logic [7:0]               r_drop_cnt;
    logic [OLW-1:0]           r_line_cnt;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // After reset a channel ignores words until it sees sof or the eol
        // closing an interrupted line, so no fragment is ever buffered.
        assign w_wr[k] = in_valid[k] & (r_armed[k] | in_sof[k]);

        line_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .i_wr_en   (w_wr[k]),
            .i_wr_data ({in_eol[k], in_sof[k], in_data[k*DATA_W +: DATA_W]}),
            .i_rd_en   (w_pop[k]),
            .o_rd_data (w_head[k]),
            .o_full    (w_full[k]),
            .o_used    (w_used[k])
        );

        assign w_empty[k]    = (w_used[k] == '0);
        assign w_head_sof[k] = w_head[k][SOF_B];
        assign w_head_eol[k] = w_head[k][EOL_B];
        assign w_head_data[k*DATA_W +: DATA_W] = w_head[k][DATA_W-1:0];
        assign w_wr_eol[k]   = w_wr[k] & ~w_full[k] & in_eol[k];
        assign w_pop_eol[k]  = w_pop[k] & w_head_eol[k];
        assign w_has_line[k] = (r_lcnt[k] != '0);
    end

    assign w_accept   = r_out_valid & out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? w_head_data : '0;
    assign out_sof    = r_out_valid & (&w_head_sof);
    assign out_eol    = r_out_valid & (|w_head_eol);
    // A frame's first line counts as line 0 even before the counter is cleared.
    assign w_line_now = out_sof ? '0 : r_line_cnt;
    assign out_eof    = out_eol & (w_line_now == LAST_LINE);

    assign w_len_evt   = (r_state == SEND && w_accept && out_eol) ? ~w_head_eol : '0;
    assign w_drop_left = r_drop_mask & ~w_pop_eol;

    assign overflow  = r_overflow;
    assign len_err   = r_len_err;
    assign skew_err  = r_skew_err;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

    always_comb begin
        w_pop = '0;
        if (r_state == SEND && w_accept) w_pop = ~w_empty;
        else if (r_state == DROP)        w_pop = r_drop_mask & ~w_empty;
    end

    always_comb begin
        w_skew_now = '0;
        w_min_lcnt = r_lcnt[0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (r_lcnt[k] < w_min_lcnt) w_min_lcnt = r_lcnt[k];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            w_skew_now[k] = ({1'b0, r_lcnt[k]} > ({1'b0, w_min_lcnt} + (UW+1)'(MAX_SKEW)));
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_lcnt[k] <= '0;
            r_armed     <= '0;
            r_skew_prev <= '0;
            r_drop_mask <= '0;
            r_overflow  <= '0;
            r_len_err   <= '0;
            r_skew_err  <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_line_cnt  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_lcnt[k] <= r_lcnt[k] + UW'(w_wr_eol[k]) - UW'(w_pop_eol[k]);
            end
            r_armed     <= r_armed | (in_valid & (in_sof | in_eol));
            r_skew_prev <= w_skew_now;

            // Skew is flagged on the rising condition so clr_err sticks while it persists.
            r_overflow <= (r_overflow & ~{NUM_CH{clr_err}}) | (w_wr & w_full);
            r_len_err  <= (r_len_err  & ~{NUM_CH{clr_err}}) | w_len_evt;
            r_skew_err <= (r_skew_err & ~{NUM_CH{clr_err}}) | (w_skew_now & ~r_skew_prev);

            if (w_accept && out_sof) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_accept) begin
                if (out_eol) begin
                    if (w_line_now == LAST_LINE) r_line_cnt <= LAST_LINE;
                    else                         r_line_cnt <= w_line_now + 1'b1;
                end else if (out_sof) begin
                    r_line_cnt <= '0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (&w_has_line) r_state <= ALIGN;
                end
                ALIGN: begin
                    if ((&w_head_sof) || !(|w_head_sof)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= SEND;
                    end else begin
                        r_drop_mask <= ~w_head_sof;
                        r_drop_cnt  <= r_drop_cnt + 8'd1;
                        r_state     <= DROP;
                    end
                end
                SEND: begin
                    if (w_accept && out_eol) begin
                        r_out_valid <= 1'b0;
                        if (|w_len_evt) begin
                            r_drop_mask <= w_len_evt;
                            r_state     <= DROP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    r_drop_mask <= w_drop_left;
                    if (w_drop_left == '0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_line_aligner.sv
// Scoreboard bench for stereo_line_aligner: expected pixels are queued as lines
// are driven and compared against every cycle the aligner presents output.
module tb_stereo_line_aligner;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
    localparam int LPF    = 720;
    localparam int VW     = NUM_CH*DATA_W + 3;

    logic                     clk_sys = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_sof;
    logic [NUM_CH-1:0]        in_eol;
    logic                     out_ready;
    logic                     out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_sof;
    logic                     out_eol;
    logic                     out_eof;
    logic                     clr_err;
    logic [NUM_CH-1:0]        overflow;
    logic [NUM_CH-1:0]        len_err;
    logic [NUM_CH-1:0]        skew_err;
    logic [7:0]               frame_cnt;
    logic [7:0]               drop_cnt;

    logic [VW-1:0] exp_q [$];
    int            exp_line = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic          toggle_rdy = 1'b0;

    stereo_line_aligner #(
        .NUM_CH          (NUM_CH),
        .DATA_W          (DATA_W),
        .FIFO_DEPTH      (2048),
        .LINES_PER_FRAME (LPF),
        .MAX_SKEW        (2)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .clr_err   (clr_err),
        .overflow  (overflow),
        .len_err   (len_err),
        .skew_err  (skew_err),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int ch, input int tag, input int i);
        return 8'((tag*13 + i*3 + ch*101) % 256);
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_line(input int tag, input int len, input logic sof);
        int   idx;
        logic e;
        idx = sof ? 0 : exp_line;
        for (int i = 0; i < len; i++) begin
            e = (i == len - 1);
            exp_q.push_back({e && (idx == LPF - 1), e, sof && (i == 0), pix(1, tag, i), pix(0, tag, i)});
        end
        exp_line = (idx == LPF - 1) ? idx : idx + 1;
    endtask

    task automatic drive_lines(input int tag, input int len0, input int len1,
                               input logic sof, input logic eol);
        int n;
        n = (len0 > len1) ? len0 : len1;
        for (int i = 0; i < n; i++) begin
            in_valid = {i < len1, i < len0};
            in_data  = {pix(1, tag, i), pix(0, tag, i)};
            in_sof   = {2{sof && (i == 0)}};
            in_eol   = {eol && (i == len1 - 1), eol && (i == len0 - 1)};
            cycles(1);
        end
        in_valid = '0;
        in_sof   = '0;
        in_eol   = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cycles(1);
            t++;
        end
        cycles(6);
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_flags",  {out_valid, out_sof, out_eol, out_eof}, 0);
        check_eq("rst_data",   out_data, 0);
        check_eq("rst_sticky", {overflow, len_err, skew_err}, 0);
        check_eq("rst_counts", {frame_cnt, drop_cnt}, 0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        cycles(1);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk_sys);
            #1;
            out_ready = toggle_rdy ? ~out_ready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_out", out_valid, 1'b0);
                end else begin
                    check_eq("pixel", {out_eof, out_eol, out_sof, out_data}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        in_sof   = '0;
        in_eol   = '0;
        clr_err  = 1'b0;
        cycles(3);
        check_reset_state();
        reset = 1'b0;
        cycles(2);

        // Two identical 1280-pixel lines starting a frame
        push_line(1, 1280, 1'b1);
        drive_lines(1, 1280, 1280, 1'b1, 1'b1);
        wait_drain("drain_long", 3000);
        check_eq("frame_cnt_first", frame_cnt, 1);

        // Back-pressure on alternate cycles
        toggle_rdy = 1'b1;
        for (int t = 2; t < 4; t++) begin
            push_line(t, 64, 1'b0);
            drive_lines(t, 64, 64, 1'b0, 1'b1);
        end
        wait_drain("drain_stall", 1000);
        toggle_rdy = 1'b0;

        // Short line on ch1 truncates the output line and flushes ch0
        push_line(4, 1279, 1'b0);
        drive_lines(4, 1280, 1279, 1'b0, 1'b1);
        push_line(5, 16, 1'b0);
        drive_lines(5, 16, 16, 1'b0, 1'b1);
        wait_drain("drain_len", 3000);
        check_eq("len_err_set", len_err, 2'b01);
        check_eq("drop_cnt_len", drop_cnt, 0);
        pulse_clr();
        check_eq("len_err_clr", len_err, 2'b00);

        // ch1 starts one line late: ch0's leading non-sof line is dropped
        drive_lines(6, 8, 0, 1'b0, 1'b1);
        push_line(7, 8, 1'b1);
        drive_lines(7, 8, 8, 1'b1, 1'b1);
        wait_drain("drain_drop", 500);
        check_eq("drop_cnt_one", drop_cnt, 1);
        check_eq("frame_cnt_drop", frame_cnt, 2);

        // ch1 stalled while ch0 buffers three lines
        for (int t = 8; t < 11; t++) drive_lines(t, 8, 0, 1'b0, 1'b1);
        cycles(2);
        check_eq("skew_set", skew_err, 2'b01);
        pulse_clr();
        check_eq("skew_clr", skew_err, 2'b00);
        for (int t = 8; t < 11; t++) begin
            push_line(t, 8, 1'b0);
            drive_lines(t, 0, 8, 1'b0, 1'b1);
        end
        wait_drain("drain_skew", 500);
        check_eq("skew_after", skew_err, 2'b00);

        // Fill ch0 past its depth without ever closing the line
        drive_lines(20, 2050, 0, 1'b0, 1'b0);
        cycles(2);
        check_eq("overflow_set", overflow, 2'b01);

        // Reset mid-line; the tail of the interrupted line must never appear
        drive_lines(21, 5, 5, 1'b1, 1'b0);
        reset = 1'b1;
        cycles(2);
        check_reset_state();
        reset    = 1'b0;
        exp_line = 0;
        cycles(1);
        drive_lines(22, 3, 3, 1'b0, 1'b1);

        // Full frame of short lines
        for (int l = 0; l < LPF; l++) begin
            push_line(100 + l, 4, l == 0);
            drive_lines(100 + l, 4, 4, l == 0, 1'b1);
        end
        wait_drain("drain_frame", 8000);
        check_eq("frame_cnt_frame", frame_cnt, 1);
        check_eq("drop_cnt_frame", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
